// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor.
// One full-adder cell plus a carry flop, iterated LSB-first over WIDTH cycles
// behind a Start/Done handshake.
//
// Optional feature macro: SERIAL_ADDSUB_SUB_EN
//   defined   -> Sub selects A-B (1) or A+B (0)
//   undefined -> Sub is ignored; the block is an adder only
//
// Ports:
//   Clk      in   1      system clock, rising edge
//   Reset_n  in   1      asynchronous active-low reset
//   Start    in   1      request operation (sampled in IDLE or DONE)
//   Sub      in   1      1 = A-B, 0 = A+B (sampled with Start)
//   A, B     in   WIDTH  operands (sampled with Start)
//   Busy     out  1      high while shifting
//   Done     out  1      one-cycle result-valid pulse
//   S        out  WIDTH  result, held until the next accepted Start
//   Cout     out  1      carry out of MSB (subtract: 1 = no borrow)
//   Ovf      out  1      signed overflow
module serial_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   ra_q, ra_d;
    logic [WIDTH-1:0]   rb_q, rb_d;
    logic [WIDTH-1:0]   racc_q, racc_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sub_eff;
    logic               s_bit;
    logic               c_nxt;

`ifdef SERIAL_ADDSUB_SUB_EN
    assign sub_eff = Sub;
`else
    // Sub port kept for a uniform interface; it has no effect in this build.
    logic unused_sub;
    assign unused_sub = Sub;
    assign sub_eff    = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            racc_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            racc_q  <= racc_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, full-adder cell and output capture
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        racc_d  = racc_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        s_bit = ra_q[0] ^ rb_q[0] ^ c_q;
        c_nxt = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    // Subtract as A + ~B + 1: invert B and seed the carry.
                    ra_d    = A;
                    rb_d    = sub_eff ? ~B : B;
                    c_d     = sub_eff;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                c_d    = c_nxt;
                racc_d = {s_bit, racc_q[WIDTH-1:1]};
                ra_d   = ra_q >> 1;
                rb_d   = rb_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // MSB cell: c_q is the carry into the MSB.
                    s_d     = {s_bit, racc_q[WIDTH-1:1]};
                    cout_d  = c_nxt;
                    ovf_d   = c_q ^ c_nxt;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=16). Expected results come from
// a word-level arithmetic model pushed into a scoreboard queue at Start.
module tb_serial_addsub;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic         Sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] S;
    logic         Cout;
    logic         Ovf;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    serial_addsub #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Start  (Start),
        .Sub    (Sub),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .S      (S),
        .Cout   (Cout),
        .Ovf    (Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        exp_t         e;
        logic         se;
        logic [W-1:0] bb;
        logic [W:0]   sum;
`ifdef SERIAL_ADDSUB_SUB_EN
        se = sub;
`else
        se = 1'b0;
`endif
        bb     = se ? ~b : b;
        sum    = {1'b0, a} + {1'b0, bb} + (W+1)'(se);
        e.s    = sum[W-1:0];
        e.cout = sum[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
        return e;
    endfunction

    // Present one Start cycle and record the expected result.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge Clk);
        A = a; B = b; Sub = sub; Start = 1'b1;
        sb.push_back(model(a, b, sub));
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Bounded wait for Done; counts Busy samples seen on the way.
    task automatic wait_done(output bit ok, output int busy_n);
        ok = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 64; i++) begin
            if (Done) begin
                ok = 1'b1;
                break;
            end
            if (Busy) busy_n++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Start = 1'b0; Sub = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Busy, Done, S, Cout, Ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b s=%h cout=%b ovf=%b, required all 0", Busy, Done, S, Cout, Ovf);
        end
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", Busy, Done);
        end
    endtask

    task automatic test_arith;
        logic [W-1:0] ta [0:9];
        logic [W-1:0] tb_ [0:9];
        logic         ts [0:9];
        bit           ok;
        int           bn;
        exp_t         e;
        logic [W-1:0] s_hold;
        ta[0] = 16'h0005; tb_[0] = 16'h0003; ts[0] = 1'b0;
        ta[1] = 16'hFFFF; tb_[1] = 16'h0001; ts[1] = 1'b0;
        ta[2] = 16'h7FFF; tb_[2] = 16'h0001; ts[2] = 1'b0;
        ta[3] = 16'h0003; tb_[3] = 16'h0005; ts[3] = 1'b1;
        ta[4] = 16'h8000; tb_[4] = 16'h0001; ts[4] = 1'b1;
        ta[5] = 16'h8000; tb_[5] = 16'h8000; ts[5] = 1'b0;
        for (int i = 6; i < 10; i++) begin
            ta[i] = W'($urandom); tb_[i] = W'($urandom); ts[i] = 1'($urandom);
        end
        for (int i = 0; i < 10; i++) begin
            drive_start(ta[i], tb_[i], ts[i]);
            wait_done(ok, bn);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL arith_timeout[%0d]: done never seen, required within 64 cycles", i);
                void'(sb.pop_front());
                continue;
            end
            e = sb.pop_front();
            checks++;
            if (bn !== int'(W)) begin
                errors++;
                $display("FAIL arith_busy_len[%0d]: %0d cycles, required %0d", i, bn, W);
            end
            checks++;
            if (S !== e.s) begin
                errors++;
                $display("FAIL arith_s[%0d]: a=%h b=%h sub=%b s=%h, required %h", i, ta[i], tb_[i], ts[i], S, e.s);
            end
            checks++;
            if (Cout !== e.cout) begin
                errors++;
                $display("FAIL arith_cout[%0d]: a=%h b=%h sub=%b cout=%b, required %b", i, ta[i], tb_[i], ts[i], Cout, e.cout);
            end
            checks++;
            if (Ovf !== e.ovf) begin
                errors++;
                $display("FAIL arith_ovf[%0d]: a=%h b=%h sub=%b ovf=%b, required %b", i, ta[i], tb_[i], ts[i], Ovf, e.ovf);
            end
            s_hold = e.s;
            @(negedge Clk);
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0 || S !== s_hold) begin
                errors++;
                $display("FAIL arith_after_done[%0d]: done=%b busy=%b s=%h, required 0 0 %h", i, Done, Busy, S, s_hold);
            end
        end
    endtask

    task automatic test_start_ignored;
        bit   ok;
        int   bn;
        exp_t e;
        drive_start(16'h0001, 16'h0001, 1'b0);
        repeat (5) @(negedge Clk);
        A = 16'h1234; B = 16'h1234; Sub = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; A = '0; B = '0; Sub = 1'b0;
        wait_done(ok, bn);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ignored_timeout: done never seen, required within 64 cycles");
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (S !== e.s || bn !== int'(W) - 6) begin
            errors++;
            $display("FAIL ignored_start: s=%h busy_left=%0d, required %h %0d", S, bn, e.s, int'(W) - 6);
        end
        @(negedge Clk);
    endtask

    task automatic test_back_to_back;
        bit   ok;
        int   bn;
        exp_t e;
        drive_start(16'h1000, 16'h0234, 1'b0);
        wait_done(ok, bn);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_first_timeout: done never seen, required within 64 cycles");
            sb.delete();
            return;
        end
        e = sb.pop_front();
        checks++;
        if (S !== e.s) begin
            errors++;
            $display("FAIL b2b_first_s: s=%h, required %h", S, e.s);
        end
        // Start while Done is high: accepted on the edge leaving DONE.
        A = 16'h0010; B = 16'h0020; Sub = 1'b0; Start = 1'b1;
        sb.push_back(model(16'h0010, 16'h0020, 1'b0));
        @(negedge Clk);
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0 || S !== e.s) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b s=%h, required 1 0 %h", Busy, Done, S, e.s);
        end
        wait_done(ok, bn);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_second_timeout: done never seen, required within 64 cycles");
            sb.delete();
            return;
        end
        e = sb.pop_front();
        checks++;
        if (S !== e.s || Cout !== e.cout || Ovf !== e.ovf || bn !== int'(W)) begin
            errors++;
            $display("FAIL b2b_second: s=%h cout=%b ovf=%b busy=%0d, required %h %b %b %0d", S, Cout, Ovf, bn, e.s, e.cout, e.ovf, W);
        end
        @(negedge Clk);
    endtask

    task automatic test_mid_reset;
        int saw_done;
        drive_start(16'h1111, 16'h2222, 1'b0);
        repeat (6) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, S, Cout, Ovf} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b s=%h cout=%b ovf=%b, required all 0", Busy, Done, S, Cout, Ovf);
        end
        void'(sb.pop_front());
        @(negedge Clk);
        Reset_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (Done || Busy) saw_done++;
        end
        checks++;
        if (saw_done !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: %0d active cycles after release, required 0", saw_done);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_start_ignored();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
